// File: rtl/vx_commit_arb_scalar.sv
// Per-slot commit arbiter: each issue slot round-robins its ALU/LSU/SFU result
// sources into a single pipe register and retires it to the issue/commit stage.
module vx_commit_arb_scalar #(
  parameter int ISSUE_CNT = 4,
  parameter int DATAW     = 64,
  parameter int CNT_W     = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [3*ISSUE_CNT-1:0]         src_valid,
  output logic [3*ISSUE_CNT-1:0]         src_ready,
  input  logic [3*ISSUE_CNT*DATAW-1:0]   src_data,
  input  logic [3*ISSUE_CNT-1:0]         src_wb,
  input  logic [3*ISSUE_CNT-1:0]         src_eop,
  output logic [ISSUE_CNT-1:0]           commit_if_valid,
  input  logic [ISSUE_CNT-1:0]           commit_if_ready,
  output logic [ISSUE_CNT-1:0]           wb_valid,
  output logic [ISSUE_CNT*DATAW-1:0]     wb_data,
  output logic [ISSUE_CNT-1:0]           wb_eop,
  output logic [ISSUE_CNT*CNT_W-1:0]     instret,
  output logic [3*ISSUE_CNT-1:0]         dbg_arb_state_o
);

  // Handshake: a transfer fires on a cycle where valid & ready are both high at
  // the clock edge; valid never waits on ready, but src_ready may depend on
  // src_valid (ready is only raised for the source that won arbitration).

  function automatic logic [1:0] next3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  for (genvar g = 0; g < ISSUE_CNT; g++) begin : g_slot
    logic [2:0]       valid_s;
    logic [2:0]       ready_s;
    logic [1:0]       rr_q, rr_d;
    logic             lock_q, lock_d;
    logic [1:0]       lock_src_q, lock_src_d;
    logic [1:0]       c0, c1, c2;
    logic [1:0]       win;
    logic             gnt_any;
    logic             enq_ok;
    logic             fire;
    logic             commit_fire;
    logic [DATAW-1:0] in_data;
    logic             in_wb, in_eop;
    logic             vld_q, vld_d;
    logic [DATAW-1:0] data_q, data_d;
    logic             wb_q, wb_d;
    logic             eop_q, eop_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign valid_s     = src_valid[3*g +: 3];
    assign c0          = rr_q;
    assign c1          = next3(c0);
    assign c2          = next3(c1);
    assign enq_ok      = ~vld_q | commit_if_ready[g];
    assign fire        = gnt_any & enq_ok & ~reset;
    assign commit_fire = vld_q & commit_if_ready[g];

    // Arbiter state register: round-robin pointer and packet lock.
    always_ff @(posedge clk) begin
      if (reset) begin
        rr_q       <= 2'd0;
        lock_q     <= 1'b0;
        lock_src_q <= 2'd0;
      end else begin
        rr_q       <= rr_d;
        lock_q     <= lock_d;
        lock_src_q <= lock_src_d;
      end
    end

    // Arbiter next state: pointer moves past the winner only when its beat is taken.
    always_comb begin
      rr_d       = rr_q;
      lock_d     = lock_q;
      lock_src_d = lock_src_q;
      if (fire) begin
        rr_d       = next3(win);
        lock_d     = ~in_eop;
        lock_src_d = win;
      end
    end

    // Arbiter outputs: a locked packet owns the slot until its eop beat.
    always_comb begin
      win     = c0;
      gnt_any = 1'b0;
      if (lock_q) begin
        win     = lock_src_q;
        gnt_any = valid_s[lock_src_q];
      end else begin
        gnt_any = |valid_s;
        if (valid_s[c2]) win = c2;
        if (valid_s[c1]) win = c1;
        if (valid_s[c0]) win = c0;
      end
    end

    always_comb begin
      ready_s = 3'b000;
      if (reset) begin
        ready_s = {2'b00, valid_s[0]};
      end else if (gnt_any && enq_ok) begin
        ready_s[win] = 1'b1;
      end
    end

    always_comb begin
      in_data = '0;
      in_wb   = 1'b0;
      in_eop  = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (win == k[1:0]) begin
          in_data = src_data[(3*g+k)*DATAW +: DATAW];
          in_wb   = src_wb[3*g+k];
          in_eop  = src_eop[3*g+k];
        end
      end
    end

    // Output pipe register: reload and drain may happen in the same cycle.
    always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      wb_d   = wb_q;
      eop_d  = eop_q;
      cnt_d  = cnt_q;
      if (commit_fire) begin
        vld_d = 1'b0;
        if (eop_q) cnt_d = cnt_q + 1'b1;
      end
      if (fire) begin
        vld_d  = 1'b1;
        data_d = in_data;
        wb_d   = in_wb;
        eop_d  = in_eop;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        vld_q  <= 1'b0;
        data_q <= '0;
        wb_q   <= 1'b0;
        eop_q  <= 1'b0;
        cnt_q  <= '0;
      end else begin
        vld_q  <= vld_d;
        data_q <= data_d;
        wb_q   <= wb_d;
        eop_q  <= eop_d;
        cnt_q  <= cnt_d;
      end
    end

    assign src_ready[3*g +: 3]       = ready_s;
    assign commit_if_valid[g]        = vld_q & ~reset;
    assign wb_valid[g]               = vld_q & commit_if_ready[g] & wb_q & ~reset;
    assign wb_data[g*DATAW +: DATAW] = data_q;
    assign wb_eop[g]                 = eop_q;
    assign instret[g*CNT_W +: CNT_W] = cnt_q;
    assign dbg_arb_state_o[3*g +: 3] = {lock_q, rr_q};
  end

endmodule

// File: tb/tb_vx_commit_arb_scalar.sv
// Bench for vx_commit_arb_scalar: source queues drive the slots, fired beats go
// into per-slot expected queues and are compared when the slot commits.
module tb_vx_commit_arb_scalar;
  localparam int IC = 4;
  localparam int DW = 16;
  localparam int CW = 4;
  localparam int NS = 3 * IC;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          wb;
    logic          eop;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [NS-1:0]     src_valid;
  logic [NS-1:0]     src_ready;
  logic [NS*DW-1:0]  src_data;
  logic [NS-1:0]     src_wb;
  logic [NS-1:0]     src_eop;
  logic [IC-1:0]     commit_if_valid;
  logic [IC-1:0]     commit_if_ready;
  logic [IC-1:0]     wb_valid;
  logic [IC*DW-1:0]  wb_data;
  logic [IC-1:0]     wb_eop;
  logic [IC*CW-1:0]  instret;
  logic [NS-1:0]     dbg_arb_state_o;

  vx_commit_arb_scalar #(.ISSUE_CNT(IC), .DATAW(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .src_wb(src_wb), .src_eop(src_eop),
    .commit_if_valid(commit_if_valid), .commit_if_ready(commit_if_ready),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_eop(wb_eop),
    .instret(instret), .dbg_arb_state_o(dbg_arb_state_o)
  );

  always #5 clk = ~clk;

  beat_t               src_q[NS][$];
  logic [$bits(beat_t)-1:0] exp_q[IC][$];
  logic [CW-1:0]       model_cnt[IC];
  logic                lock_m[IC];
  logic [1:0]          lock_src_m[IC];
  int                  log_src[IC][$];
  int                  log_cyc[IC][$];
  logic [IC-1:0]       rdy;
  logic [NS-1:0]       alu_mask = 12'b001_001_001_001;
  int                  cyc = 0;
  int                  seq = 0;
  int                  n_tests = 0;
  int                  n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_beat(input int slot, input int src, input logic wb, input logic eop);
    beat_t b;
    b.data = {slot[1:0], src[1:0], seq[11:0]};
    b.wb   = wb;
    b.eop  = eop;
    seq++;
    src_q[3*slot+src].push_back(b);
  endtask

  task automatic drive();
    for (int s = 0; s < NS; s++) begin
      src_valid[s] = (src_q[s].size() != 0);
      if (src_q[s].size() != 0) begin
        src_data[s*DW +: DW] = src_q[s][0].data;
        src_wb[s]            = src_q[s][0].wb;
        src_eop[s]           = src_q[s][0].eop;
      end else begin
        src_data[s*DW +: DW] = '0;
        src_wb[s]            = 1'b0;
        src_eop[s]           = 1'b0;
      end
    end
    commit_if_ready = rdy;
  endtask

  task automatic step();
    beat_t e;
    int    sid;
    @(negedge clk);
    drive();
    #1;
    if (reset) begin
      check("rst_cvalid", commit_if_valid, '0);
      check("rst_wb_valid", wb_valid, '0);
      check("rst_src_ready", src_ready, src_valid & alu_mask);
      for (int i = 0; i < IC; i++) begin
        exp_q[i].delete();
        model_cnt[i] = '0;
        lock_m[i]    = 1'b0;
      end
      for (int s = 0; s < NS; s++)
        if (src_valid[s] && src_ready[s]) void'(src_q[s].pop_front());
    end else begin
      for (int i = 0; i < IC; i++) begin
        check("instret", instret[i*CW +: CW], model_cnt[i]);
        check("cvalid", commit_if_valid[i], exp_q[i].size() != 0);
        check("src_ready_onehot", $countones(src_ready[3*i +: 3]) <= 1, 1);
        if (commit_if_valid[i] && exp_q[i].size() != 0) begin
          e = exp_q[i][0];
          check("wb_data", wb_data[i*DW +: DW], e.data);
          check("wb_eop", wb_eop[i], e.eop);
          check("wb_valid", wb_valid[i], rdy[i] & e.wb);
          if (!rdy[i]) check("src_ready_held", src_ready[3*i +: 3], 3'b000);
          if (rdy[i]) begin
            void'(exp_q[i].pop_front());
            sid = int'(e.data[DW-3 -: 2]);
            if (lock_m[i]) check("no_interleave", sid, lock_src_m[i]);
            lock_m[i]     = ~e.eop;
            lock_src_m[i] = sid[1:0];
            if (e.eop) model_cnt[i] = model_cnt[i] + 1'b1;
            log_src[i].push_back(sid);
            log_cyc[i].push_back(cyc);
          end
        end else begin
          check("wb_valid_idle", wb_valid[i], 1'b0);
        end
      end
      for (int s = 0; s < NS; s++) begin
        if (src_valid[s] && src_ready[s]) begin
          exp_q[s/3].push_back(src_q[s][0]);
          void'(src_q[s].pop_front());
          check("pipe_depth", exp_q[s/3].size() <= 1, 1);
        end
      end
    end
    cyc++;
  endtask

  function automatic bit pending();
    for (int s = 0; s < NS; s++) if (src_q[s].size() != 0) return 1'b1;
    for (int i = 0; i < IC; i++) if (exp_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while (pending() && n < budget) begin
      step();
      n++;
    end
    if (pending()) check("drain_timeout", 1, 0);
  endtask

  task automatic clear_logs();
    for (int i = 0; i < IC; i++) begin
      log_src[i].delete();
      log_cyc[i].delete();
    end
  endtask

  initial begin
    int c0;
    int plen;
    src_valid = '0; src_data = '0; src_wb = '0; src_eop = '0;
    commit_if_ready = '0;
    rdy = '1;
    for (int i = 0; i < IC; i++) begin
      model_cnt[i] = '0; lock_m[i] = 1'b0; lock_src_m[i] = 2'd0;
    end

    // reset
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    check("reset_instret", instret, '0);
    check("reset_arb_state", dbg_arb_state_o, '0);

    // instret wrap on slot 2
    for (int k = 0; k < 15; k++) push_beat(2, 0, 1'b1, 1'b1);
    drain(100);
    step();
    check("instret2_max", instret[2*CW +: CW], 4'd15);
    push_beat(2, 0, 1'b1, 1'b1);
    drain(20);
    step();
    check("instret2_wrap", instret[2*CW +: CW], 4'd0);

    // slot 0 round-robin ALU, LSU, SFU
    clear_logs();
    push_beat(0, 0, 1'b1, 1'b1);
    push_beat(0, 1, 1'b1, 1'b1);
    push_beat(0, 2, 1'b1, 1'b1);
    c0 = cyc;
    drain(20);
    step();
    check("rr_count", log_src[0].size(), 3);
    for (int k = 0; k < 3 && k < log_src[0].size(); k++) begin
      check("rr_order", log_src[0][k], k);
      check("rr_cycle", log_cyc[0][k] - c0, k + 1);
    end
    check("rr_instret0", instret[0 +: CW], 4'd3);

    // slot 1 packet lock: LSU two-beat packet ahead of a waiting ALU
    push_beat(1, 0, 1'b1, 1'b1);
    drain(20);
    clear_logs();
    push_beat(1, 1, 1'b1, 1'b0);
    push_beat(1, 1, 1'b1, 1'b1);
    push_beat(1, 0, 1'b1, 1'b1);
    c0 = cyc;
    drain(20);
    step();
    check("lock_count", log_src[1].size(), 3);
    if (log_src[1].size() == 3) begin
      check("lock_src0", log_src[1][0], 1);
      check("lock_src1", log_src[1][1], 1);
      check("lock_src2", log_src[1][2], 0);
      check("lock_cyc2", log_cyc[1][2] - c0, 3);
    end
    check("lock_instret1", instret[CW +: CW], 4'd3);

    // slot 0 back-pressure for several cycles
    rdy[0] = 1'b0;
    push_beat(0, 0, 1'b1, 1'b1);
    push_beat(0, 0, 1'b1, 1'b1);
    push_beat(0, 1, 1'b1, 1'b1);
    repeat (6) step();
    check("held_cvalid", commit_if_valid[0], 1'b1);
    rdy[0] = 1'b1;
    drain(20);
    step();
    check("held_instret0", instret[0 +: CW], 4'd6);

    // no-writeback result still retires
    push_beat(0, 2, 1'b0, 1'b1);
    drain(20);
    step();
    check("nowb_instret0", instret[0 +: CW], 4'd7);

    // random packets with random commit back-pressure
    for (int s = 0; s < NS; s++) begin
      for (int p = 0; p < 4; p++) begin
        plen = $urandom_range(1, 3);
        for (int b = 0; b < plen; b++)
          push_beat(s / 3, s % 3, 1'($urandom_range(0, 1)), b == plen - 1);
      end
    end
    begin
      int n = 0;
      while (pending() && n < 3000) begin
        rdy = 4'($urandom_range(0, 15));
        step();
        n++;
      end
      if (pending()) check("random_timeout", 1, 0);
    end
    rdy = '1;
    step();

    // reset while slot 3 holds a locked first beat
    rdy[3] = 1'b0;
    push_beat(3, 2, 1'b1, 1'b0);
    push_beat(3, 2, 1'b1, 1'b1);
    step();
    step();
    check("pre_reset_lock", dbg_arb_state_o[3*3+2], 1'b1);
    check("pre_reset_cvalid", commit_if_valid[3], 1'b1);
    for (int s = 0; s < NS; s++) src_q[s].delete();
    rdy = '1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("post_reset_arb3", dbg_arb_state_o[3*3 +: 3], 3'b000);
    check("post_reset_cvalid", commit_if_valid, '0);
    check("post_reset_wb_valid", wb_valid, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vx_commit_arb_scalar.md
VX_COMMIT_ARB_SCALAR -- requirements
Module: VX_commit_arb_scalar

Interface
REQ-001 Parameter ISSUE_CNT, default 4, number of independent issue slots.
REQ-002 Parameter DATAW, default 64, opaque result payload width per source (uuid/wid/PC/tmask/rd/data packed by sender).
REQ-003 Parameter CNT_W, default 32, per-slot retired-instruction counter width.
REQ-004 clk  in  1  clock.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 src_valid  in  3*ISSUE_CNT  per slot i, bits [3i+0]=ALU, [3i+1]=LSU, [3i+2]=SFU result valid.
REQ-007 src_ready  out  3*ISSUE_CNT  per source ready, same indexing.
REQ-008 src_data  in  3*ISSUE_CNT*DATAW  per source payload, same indexing, DATAW slices.
REQ-009 src_wb  in  3*ISSUE_CNT  per source register-writeback request.
REQ-010 src_eop  in  3*ISSUE_CNT  per source end-of-packet (last beat of instruction).
REQ-011 commit_if_valid  out  ISSUE_CNT  slot result pending commit (consumed by issue stage).
REQ-012 commit_if_ready  in  ISSUE_CNT  issue/commit consumer accepts slot result.
REQ-013 wb_valid  out  ISSUE_CNT  register-file write strobe.
REQ-014 wb_data  out  ISSUE_CNT*DATAW  payload of committed result.
REQ-015 wb_eop  out  ISSUE_CNT  eop of committed result.
REQ-016 instret  out  ISSUE_CNT*CNT_W  per-slot retired-instruction count.

Function
REQ-017 Each slot SHALL be fully independent; no cross-slot state or arbitration.
REQ-018 Each slot SHALL hold one output register {vld, data, wb, eop}; commit_if_valid[i] = vld.
REQ-019 Slot accepts a new result when enq_ok = ~vld | commit_if_ready[i] (pipe register, full throughput).
REQ-020 Arbitration: round-robin among the 3 sources of the slot; priority order starts at rr_ptr, then rr_ptr+1, rr_ptr+2 (mod 3).
REQ-021 src_ready for the granted source SHALL equal enq_ok; non-granted sources SHALL see src_ready=0.
REQ-022 rr_ptr (2-bit, values 0..2) SHALL advance to (winner+1) mod 3 only on a grant that fires; unchanged otherwise; value 3 never reached.
REQ-023 Packets SHALL not interleave: after a granted beat with eop=0, grant SHALL lock to that source until its eop=1 beat fires.
REQ-024 Latency: source fire in cycle N -> commit_if_valid=1 in cycle N+1 with identical data/wb/eop.
REQ-025 Held result SHALL remain stable while commit_if_valid=1 and commit_if_ready=0.
REQ-026 wb_valid[i] = vld & commit_if_ready[i] & wb (combinational); wb_data/wb_eop = register contents.
REQ-027 Commit with wb=0 SHALL fire handshake but assert no wb_valid.
REQ-028 instret[i] SHALL increment by 1 on each commit fire with eop=1; wraps modulo 2^CNT_W.
REQ-029 Simultaneous commit fire and new grant in one cycle: register reloads, vld stays 1, no bubble.
REQ-030 No source valid and commit fires: vld clears next cycle.

Reset
REQ-031 On reset: vld=0, rr_ptr=0, lock cleared, instret=0; commit_if_valid=0, wb_valid=0, src_ready = 1 for source 0 (ALU) of each slot only while its valid is asserted, else 0.
REQ-032 Reset mid-packet SHALL drop held/locked state without emitting any wb_valid in the reset cycle or the following cycle.

Verification
REQ-033 Slot 0: ALU, LSU, SFU all valid with eop=1, wb=1, commit_if_ready=1 constant -> commits in order ALU, LSU, SFU on cycles 1,2,3; instret[0]=3.
REQ-034 Slot 1: LSU 2-beat packet (eop 0 then 1) with ALU valid throughout -> both LSU beats commit back-to-back before ALU; instret[1] increments once.
REQ-035 Slot 0 commit_if_ready=0 for 5 cycles with result held -> commit_if_valid stays 1, payload unchanged, wb_valid=0, all src_ready=0.
REQ-036 Result with wb=0, eop=1 -> handshake fires, wb_valid=0, instret increments.
REQ-037 Preload instret[2] to 2^CNT_W-1 via commits (CNT_W=4, 15 commits) then one more -> instret[2]=0.
REQ-038 Assert reset while slot 3 holds locked first beat -> next cycle vld=0, lock cleared, rr_ptr=0, no wb_valid.
